// File: rtl/kbd_pkg.sv
// Shared types and scan-code constants for the keyboard event queue.
package kbd_pkg;

  localparam logic [7:0] SC_EXT    = 8'hE0;
  localparam logic [7:0] SC_BRK    = 8'hF0;
  localparam logic [7:0] SC_LSHIFT = 8'h12;
  localparam logic [7:0] SC_RSHIFT = 8'h59;
  localparam logic [7:0] SC_CAPS   = 8'h58;
  localparam logic [7:0] SC_SPACE  = 8'h29;
  localparam logic [7:0] SC_ENTER  = 8'h5A;
  localparam logic [7:0] SC_BKSP   = 8'h66;

  typedef struct packed {
    logic [7:0] rsv_hi;
    logic [7:0] ascii;
    logic [3:0] rsv_lo;
    logic       caps;
    logic       shift;
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } kbd_event_t;

endpackage

// File: rtl/ps2_ascii_lut.sv
// Scan-code set 2 to ASCII translation for letters, digits and a few control keys.
module ps2_ascii_lut
  import kbd_pkg::*;
(
  input  logic [7:0] code,
  input  logic       shift,
  input  logic       caps,
  output logic [7:0] ascii
);

  logic [7:0] letter;

  // NOTE: every output of a combinational block gets a default first, otherwise
  // an unlisted case leaves it holding its old value and a latch is inferred.
  always_comb begin
    letter = 8'h00;
    ascii  = 8'h00;
    case (code)
      8'h1C: letter = 8'h61; 8'h32: letter = 8'h62; 8'h21: letter = 8'h63;
      8'h23: letter = 8'h64; 8'h24: letter = 8'h65; 8'h2B: letter = 8'h66;
      8'h34: letter = 8'h67; 8'h33: letter = 8'h68; 8'h43: letter = 8'h69;
      8'h3B: letter = 8'h6A; 8'h42: letter = 8'h6B; 8'h4B: letter = 8'h6C;
      8'h3A: letter = 8'h6D; 8'h31: letter = 8'h6E; 8'h44: letter = 8'h6F;
      8'h4D: letter = 8'h70; 8'h15: letter = 8'h71; 8'h2D: letter = 8'h72;
      8'h1B: letter = 8'h73; 8'h2C: letter = 8'h74; 8'h3C: letter = 8'h75;
      8'h2A: letter = 8'h76; 8'h1D: letter = 8'h77; 8'h22: letter = 8'h78;
      8'h35: letter = 8'h79; 8'h1A: letter = 8'h7A;
      default: letter = 8'h00;
    endcase

    if (letter != 8'h00) begin
      // Lowercase and uppercase differ only in bit 5.
      ascii = (shift ^ caps) ? (letter - 8'h20) : letter;
    end else begin
      case (code)
        8'h16:     ascii = shift ? 8'h21 : 8'h31;
        8'h1E:     ascii = shift ? 8'h40 : 8'h32;
        8'h26:     ascii = shift ? 8'h23 : 8'h33;
        8'h25:     ascii = shift ? 8'h24 : 8'h34;
        8'h2E:     ascii = shift ? 8'h25 : 8'h35;
        8'h36:     ascii = shift ? 8'h5E : 8'h36;
        8'h3D:     ascii = shift ? 8'h26 : 8'h37;
        8'h3E:     ascii = shift ? 8'h2A : 8'h38;
        8'h46:     ascii = shift ? 8'h28 : 8'h39;
        8'h45:     ascii = shift ? 8'h29 : 8'h30;
        SC_SPACE:  ascii = 8'h20;
        SC_ENTER:  ascii = 8'h0D;
        SC_BKSP:   ascii = 8'h08;
        default:   ascii = 8'h00;
      endcase
    end
  end

endmodule

// File: rtl/kbd_event_queue.sv
// Turns each new nonzero scan word into a decoded key event and queues it in a
// first-word-fall-through FIFO read by the CPU.
module kbd_event_queue
  import kbd_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic [31:0]      cur_key,
  input  logic             rd_en,
  input  logic             flush,
  input  logic             clr_ovf,
  input  logic             irq_en,
  output logic [31:0]      rd_data,
  output logic             rd_valid,
  output logic [CNT_W-1:0] count,
  output logic             ovf,
  output logic             irq
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [31:0]      cur_q, last_key;
  logic             shift_l, shift_r, caps;
  logic             shift_l_nx, shift_r_nx, caps_nx;
  logic             new_evt, brk, ext;
  logic [7:0]       code, ascii;
  kbd_event_t       evt;
  kbd_event_t       mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] cnt;
  logic             empty, full, pop, push, drop, wr;

  assign code    = cur_q[7:0];
  assign brk     = (cur_q[15:8] == SC_BRK);
  assign ext     = (cur_q[15:8] == SC_EXT) || (cur_q[23:16] == SC_EXT);
  assign new_evt = (cur_q != 32'h0) && (cur_q != last_key);

  // The event reports modifier state including its own effect.
  always_comb begin
    shift_l_nx = shift_l;
    shift_r_nx = shift_r;
    caps_nx    = caps;
    if (new_evt && !ext) begin
      if (code == SC_LSHIFT)          shift_l_nx = !brk;
      if (code == SC_RSHIFT)          shift_r_nx = !brk;
      if (code == SC_CAPS && !brk)    caps_nx    = !caps;
    end
  end

  ps2_ascii_lut u_lut (
    .code  (code),
    .shift (shift_l_nx | shift_r_nx),
    .caps  (caps_nx),
    .ascii (ascii)
  );

  always_comb begin
    evt       = '0;
    evt.code  = code;
    evt.brk   = brk;
    evt.ext   = ext;
    evt.shift = shift_l_nx | shift_r_nx;
    evt.caps  = caps_nx;
    evt.ascii = ext ? 8'h00 : ascii;
  end

  assign empty = (cnt == '0);
  assign full  = (cnt == CNT_W'(DEPTH));
  assign pop   = rd_en && !empty && !flush;
  assign push  = new_evt && !flush;
  assign drop  = push && full && !pop;
  assign wr    = push && !drop;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      cur_q    <= '0;
      last_key <= '0;
      shift_l  <= 1'b0;
      shift_r  <= 1'b0;
      caps     <= 1'b0;
    end else begin
      cur_q   <= cur_key;
      shift_l <= shift_l_nx;
      shift_r <= shift_r_nx;
      caps    <= caps_nx;
      if (new_evt) last_key <= cur_q;
    end
  end

  // NOTE: the storage array has no reset; unread slots are masked by the
  // empty check on rd_data, so clearing them would only cost flops.
  always_ff @(posedge clk) begin
    if (wr) mem[wr_ptr] <= evt;
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      ovf    <= 1'b0;
    end else begin
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        cnt    <= '0;
      end else begin
        if (wr)  wr_ptr <= wr_ptr + PTR_W'(1);
        if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
        cnt <= cnt + CNT_W'(wr) - CNT_W'(pop);
      end
      if (drop)         ovf <= 1'b1;
      else if (clr_ovf) ovf <= 1'b0;
    end
  end

  assign rd_data  = empty ? 32'h0 : mem[rd_ptr];
  assign rd_valid = !empty;
  assign count    = cnt;
  assign irq      = !empty && irq_en;

endmodule
